// File: rtl/display_mux_7seg_if.sv
// Bus between the 7-segment scan controller and its surroundings:
// scan control and digit data in, decoder nibble and anode drive out.
interface display_mux_7seg_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      en;
    logic [4*NUM_DIGITS-1:0]   num;
    logic [3:0]                bcd;
    logic [NUM_DIGITS-1:0]     an;
    logic [2:0]                digit_idx;
    logic                      frame_done;

    modport master (
        output en, num,
        input  bcd, an, digit_idx, frame_done
    );

    modport slave (
        input  en, num,
        output bcd, an, digit_idx, frame_done
    );
endinterface

// File: rtl/display_mux_7seg.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with per-slot dead time.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZ_BLANK_EN.
module display_mux_7seg #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DIV_COUNT   = 50000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    display_mux_7seg_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DIV_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
    logic [3:0]                bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]     blank;

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        if (bus.en) begin
            if (cnt_q == '0 && idx_q == '0) begin
                shadow_d = bus.num;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef DISPLAY_LZ_BLANK_EN
    // Walk from the most significant digit down; a digit is blanked while every nibble from it upward is zero.
    always_comb begin
        logic zero_run;
        blank    = '0;
        zero_run = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            zero_run = zero_run && (shadow_d[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            blank[NUM_DIGITS-1-k] = zero_run;
        end
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    // Outputs are registered from next state so they line up with the state they describe.
    always_comb begin
        bcd_d        = bcd_q;
        an_d         = '1;
        frame_done_d = bus.en && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
        if (bus.en) begin
            bcd_d = '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == 3'(i)) begin
                    bcd_d   = shadow_d[4*i +: 4];
                    an_d[i] = !((cnt_d >= DEAD_END) && !blank[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            bcd_q        <= '0;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            bcd_q        <= bcd_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.bcd        = bcd_q;
    assign bus.an         = an_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_display_mux_7seg.sv
// Directed self-checking bench for display_mux_7seg (4 digits, 4-cycle slots, 1 dead cycle).
// Leading-zero blanking checks run when DISPLAY_LZ_BLANK_EN is defined.
module tb_display_mux_7seg;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    display_mux_7seg_if #(.NUM_DIGITS(4)) dif ();

    display_mux_7seg #(
        .NUM_DIGITS (4),
        .DIV_COUNT  (4),
        .DEAD_CYCLES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        dif.en  = 1'b0;
        dif.num = 16'h0000;
        repeat (3) tick();
        n_checks++;
        if (dif.an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", dif.an); end
        n_checks++;
        if (dif.bcd !== 4'h0) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0", dif.bcd); end
        n_checks++;
        if (dif.digit_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", dif.digit_idx); end
        n_checks++;
        if (dif.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", dif.frame_done); end
    endtask

    // First frame of 16'h1234; num switches to 16'hABCD mid digit-2 slot without effect on this frame.
    task automatic test_scan();
        logic [3:0] exp_bcd [16];
        logic [3:0] exp_an  [16];
        exp_bcd = '{4'h4,4'h4,4'h4,4'h3,4'h3,4'h3,4'h3,4'h2,4'h2,4'h2,4'h2,4'h1,4'h1,4'h1,4'h1,4'h4};
        exp_an  = '{4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hF,4'hB,4'hB,4'hB,4'hF,4'h7,4'h7,4'h7,4'hF};
        rst     = 1'b0;
        dif.en  = 1'b1;
        dif.num = 16'h1234;
        for (int e = 0; e < 16; e++) begin
            tick();
            if (e == 8) dif.num = 16'hABCD;
            n_checks++;
            if (dif.bcd !== exp_bcd[e]) begin n_fail++; $display("FAIL scan_bcd edge %0d: got %h expected %h", e+1, dif.bcd, exp_bcd[e]); end
            n_checks++;
            if (dif.an !== exp_an[e]) begin n_fail++; $display("FAIL scan_an edge %0d: got %b expected %b", e+1, dif.an, exp_an[e]); end
            n_checks++;
            if (dif.frame_done !== (e == 15)) begin n_fail++; $display("FAIL scan_fd edge %0d: got %b expected %b", e+1, dif.frame_done, (e == 15)); end
        end
    endtask

    task automatic test_reload();
        logic [3:0] exp_bcd [16];
        logic [3:0] exp_an  [16];
        exp_bcd = '{4'hD,4'hD,4'hD,4'hC,4'hC,4'hC,4'hC,4'hB,4'hB,4'hB,4'hB,4'hA,4'hA,4'hA,4'hA,4'hD};
        exp_an  = '{4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hF,4'hB,4'hB,4'hB,4'hF,4'h7,4'h7,4'h7,4'hF};
        for (int e = 0; e < 16; e++) begin
            tick();
            n_checks++;
            if (dif.bcd !== exp_bcd[e]) begin n_fail++; $display("FAIL reload_bcd edge %0d: got %h expected %h", e+1, dif.bcd, exp_bcd[e]); end
            n_checks++;
            if (dif.an !== exp_an[e]) begin n_fail++; $display("FAIL reload_an edge %0d: got %b expected %b", e+1, dif.an, exp_an[e]); end
        end
    endtask

    task automatic test_frame_done();
        int pulses;
        pulses = 0;
        for (int e = 1; e <= 48; e++) begin
            tick();
            if (dif.frame_done === 1'b1) begin
                pulses++;
                n_checks++;
                if (e % 16 != 0) begin n_fail++; $display("FAIL fd_position: pulse at edge %0d, required a multiple of 16", e); end
            end
        end
        n_checks++;
        if (pulses != 3) begin n_fail++; $display("FAIL fd_count: got %0d pulses expected 3", pulses); end
    endtask

    task automatic test_freeze();
        repeat (6) tick();
        n_checks++;
        if (dif.an !== 4'b1101 || dif.bcd !== 4'hC) begin
            n_fail++; $display("FAIL freeze_pre: got an=%b bcd=%h expected an=1101 bcd=c", dif.an, dif.bcd);
        end
        dif.en = 1'b0;
        for (int e = 0; e < 5; e++) begin
            tick();
            n_checks++;
            if (dif.an !== 4'b1111 || dif.digit_idx !== 3'd1 || dif.bcd !== 4'hC || dif.frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze_hold cycle %0d: got an=%b idx=%0d bcd=%h fd=%b expected an=1111 idx=1 bcd=c fd=0",
                         e, dif.an, dif.digit_idx, dif.bcd, dif.frame_done);
            end
        end
        dif.en = 1'b1;
        tick();
        n_checks++;
        if (dif.an !== 4'b1101 || dif.digit_idx !== 3'd1) begin
            n_fail++; $display("FAIL freeze_resume: got an=%b idx=%0d expected an=1101 idx=1", dif.an, dif.digit_idx);
        end
        tick();
        n_checks++;
        if (dif.an !== 4'b1111 || dif.digit_idx !== 3'd2 || dif.bcd !== 4'hB) begin
            n_fail++; $display("FAIL freeze_next_slot: got an=%b idx=%0d bcd=%h expected an=1111 idx=2 bcd=b", dif.an, dif.digit_idx, dif.bcd);
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) tick();
        n_checks++;
        if (dif.an !== 4'b1011 || dif.bcd !== 4'hB) begin
            n_fail++; $display("FAIL rstmid_pre: got an=%b bcd=%h expected an=1011 bcd=b", dif.an, dif.bcd);
        end
        dif.num = 16'h5678;
        rst     = 1'b1;
        tick();
        n_checks++;
        if (dif.digit_idx !== 3'd0 || dif.an !== 4'b1111 || dif.bcd !== 4'h0 || dif.frame_done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_abort: got idx=%0d an=%b bcd=%h fd=%b expected idx=0 an=1111 bcd=0 fd=0",
                               dif.digit_idx, dif.an, dif.bcd, dif.frame_done);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (dif.an !== 4'b1110 || dif.bcd !== 4'h8) begin
            n_fail++; $display("FAIL rstmid_reload: got an=%b bcd=%h expected an=1110 bcd=8", dif.an, dif.bcd);
        end
        repeat (3) tick();
        n_checks++;
        if (dif.an !== 4'b1111 || dif.bcd !== 4'h7 || dif.digit_idx !== 3'd1) begin
            n_fail++; $display("FAIL rstmid_digit1: got an=%b bcd=%h idx=%0d expected an=1111 bcd=7 idx=1", dif.an, dif.bcd, dif.digit_idx);
        end
    endtask

`ifdef DISPLAY_LZ_BLANK_EN
    task automatic test_lz_blank();
        logic [3:0] exp_bcd [16];
        logic [3:0] exp_an  [16];
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        dif.num = 16'h0050;
        exp_bcd = '{4'h0,4'h0,4'h0,4'h5,4'h5,4'h5,4'h5,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0};
        exp_an  = '{4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF};
        for (int e = 0; e < 16; e++) begin
            tick();
            n_checks++;
            if (dif.bcd !== exp_bcd[e] || dif.an !== exp_an[e]) begin
                n_fail++; $display("FAIL lz_0050 edge %0d: got an=%b bcd=%h expected an=%b bcd=%h", e+1, dif.an, dif.bcd, exp_an[e], exp_bcd[e]);
            end
        end
        dif.num = 16'h0000;
        exp_an  = '{4'hE,4'hE,4'hE,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF};
        for (int e = 0; e < 16; e++) begin
            tick();
            n_checks++;
            if (dif.bcd !== 4'h0 || dif.an !== exp_an[e]) begin
                n_fail++; $display("FAIL lz_0000 edge %0d: got an=%b bcd=%h expected an=%b bcd=0", e+1, dif.an, dif.bcd, exp_an[e]);
            end
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_scan();
        test_reload();
        test_frame_done();
        test_freeze();
        test_reset_mid();
`ifdef DISPLAY_LZ_BLANK_EN
        test_lz_blank();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
